// File: rtl/multiword_add_seq.sv
// Multi-word add/sub sequencer: LSW-first operand beats through a prefix adder slice, carry chained between beats.
// Latency 1 cycle, accept-to-result. in_ready = !out_valid | out_ready; a stalled result register blocks new beats.
// Backpressure: while the result is not taken, all out_* hold steady.
module multiword_add_seq #(
   parameter int LEVELS = 3,
   parameter int WIDTH  = 2**LEVELS,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_x,
   input  logic [WIDTH-1:0] in_y,
   input  logic             in_last,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_z,
   output logic [CNT_W-1:0] out_idx,
   output logic             out_last,
   output logic             out_carry,
   output logic             out_ovf,
   output logic             busy
);

   typedef enum logic {IDLE, RUN} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] z;
      logic [CNT_W-1:0] idx;
      logic             last;
      logic             carry;
      logic             ovf;
   } res_t;

   // Kogge-Stone: cin is folded into bit 0 generate, so g[i] ends up as the carry out of bit i.
   function automatic logic [WIDTH:0] prefix_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic             c0);
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] hs;
      logic [WIDTH-1:0] cv;
      hs   = a ^ b;
      g    = a & b;
      g[0] = g[0] | (hs[0] & c0);
      p    = hs;
      for (int l = 0; l < LEVELS; l++) begin
         for (int i = WIDTH - 1; i >= (1 << l); i--) begin
            g[i] = g[i] | (p[i] & g[i - (1 << l)]);
            p[i] = p[i] & p[i - (1 << l)];
         end
      end
      cv = {g[WIDTH-2:0], c0};
      return {g[WIDTH-1], hs ^ cv};
   endfunction

   state_t           state_q, state_d;
   logic             carry_q;
   logic             sub_q;
   logic             out_vld_q;
   res_t             res_q, res_d;

   logic             accept;
   logic             sub_eff;
   logic [WIDTH-1:0] y_eff;
   logic             cin_eff;
   logic [WIDTH:0]   sum;

   assign in_ready = !out_vld_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      sub_eff = sub_q;
      cin_eff = carry_q;
      res_d   = '0;

      // First beat of a transaction takes mode and carry-in from the stream.
      if (state_q == IDLE) begin
         sub_eff = in_sub;
         cin_eff = in_sub | in_cin;
      end

      y_eff = sub_eff ? ~in_y : in_y;
      sum   = prefix_add(in_x, y_eff, cin_eff);

      res_d.z    = sum[WIDTH-1:0];
      res_d.idx  = (state_q == IDLE) ? '0 : res_q.idx + CNT_W'(1);
      res_d.last = in_last;
      if (in_last) begin
         res_d.carry = sum[WIDTH];
         res_d.ovf   = (in_x[WIDTH-1] == y_eff[WIDTH-1]) &&
                       (sum[WIDTH-1] != in_x[WIDTH-1]);
      end

      if (accept) begin
         state_d = in_last ? IDLE : RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         carry_q   <= 1'b0;
         sub_q     <= 1'b0;
         out_vld_q <= 1'b0;
         res_q     <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            carry_q   <= sum[WIDTH];
            sub_q     <= sub_eff;
            res_q     <= res_d;
            out_vld_q <= 1'b1;
         end else if (out_ready) begin
            out_vld_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_vld_q;
   assign out_z     = res_q.z;
   assign out_idx   = res_q.idx;
   assign out_last  = res_q.last;
   assign out_carry = res_q.carry;
   assign out_ovf   = res_q.ovf;
   assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq at WIDTH=8: single/multi-word add and sub, flags, backpressure, index wrap, reset.
module tb_multiword_add_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_x;
   logic [7:0] in_y;
   logic       in_last;
   logic       in_cin;
   logic       in_sub;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_z;
   logic [7:0] out_idx;
   logic       out_last;
   logic       out_carry;
   logic       out_ovf;
   logic       busy;

   int compared   = 0;
   int mismatched = 0;

   multiword_add_seq #(.LEVELS(3), .WIDTH(8), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_last   (in_last),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_z     (out_z),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .out_carry (out_carry),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [20:0] obs();
      return {out_valid, out_z, out_idx, out_last, out_carry, out_ovf, busy};
   endfunction

   function automatic logic [20:0] ex(input logic v, input logic [7:0] z, input logic [7:0] idx,
                                      input logic last, input logic carry, input logic ovf,
                                      input logic bsy);
      return {v, z, idx, last, carry, ovf, bsy};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      compared++;
      assert (got === want) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   // Presents one beat starting just after a clock edge; returns just after the edge that takes it.
   task automatic send(input logic [7:0] x, input logic [7:0] y, input logic last,
                       input logic cin, input logic sub);
      int n;
      in_x     = x;
      in_y     = y;
      in_last  = last;
      in_cin   = cin;
      in_sub   = sub;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("send_timeout", 32'(n < 50), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_x      = '0;
      in_y      = '0;
      in_last   = 1'b0;
      in_cin    = 1'b0;
      in_sub    = 1'b0;
      out_ready = 1'b1;

      #22;
      check("reset_state", 32'(obs()), 32'(ex(0, 8'h00, 8'd0, 0, 0, 0, 0)));
      check("reset_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // single-word add with carry out
      send(8'hFF, 8'h01, 1, 0, 0);
      check("t1_ffp01", 32'(obs()), 32'(ex(1, 8'h00, 8'd0, 1, 1, 0, 0)));
      @(posedge clk); #1;
      check("t1_drain", 32'(out_valid), 32'd0);

      // two-word add, carry chained
      send(8'hFF, 8'h01, 0, 0, 0);
      check("t2_beat0", 32'(obs()), 32'(ex(1, 8'h00, 8'd0, 0, 0, 0, 1)));
      send(8'h00, 8'h00, 1, 0, 0);
      check("t2_beat1", 32'(obs()), 32'(ex(1, 8'h01, 8'd1, 1, 0, 0, 0)));

      // subtraction and borrow
      send(8'h05, 8'h07, 1, 0, 1);
      check("t3_5m7", 32'(obs()), 32'(ex(1, 8'hFE, 8'd0, 1, 0, 0, 0)));
      send(8'h07, 8'h05, 1, 0, 1);
      check("t3_7m5", 32'(obs()), 32'(ex(1, 8'h02, 8'd0, 1, 1, 0, 0)));

      // signed overflow corners
      send(8'h7F, 8'h01, 1, 0, 0);
      check("t4_7fp01", 32'(obs()), 32'(ex(1, 8'h80, 8'd0, 1, 0, 1, 0)));
      send(8'h80, 8'h80, 1, 0, 0);
      check("t4_80p80", 32'(obs()), 32'(ex(1, 8'h00, 8'd0, 1, 1, 1, 0)));
      send(8'h80, 8'h01, 1, 0, 1);
      check("t4_80m01", 32'(obs()), 32'(ex(1, 8'h7F, 8'd0, 1, 1, 1, 0)));

      // 0x0100 - 0x0001; in_sub/in_cin on the second beat must be ignored
      send(8'h00, 8'h01, 0, 0, 1);
      check("t4b_sub_b0", 32'(obs()), 32'(ex(1, 8'hFF, 8'd0, 0, 0, 0, 1)));
      send(8'h01, 8'h00, 1, 1, 0);
      check("t4b_sub_b1", 32'(obs()), 32'(ex(1, 8'h00, 8'd1, 1, 1, 0, 0)));
      @(posedge clk); #1;

      // backpressure: stalled result blocks the next beat
      out_ready = 1'b0;
      in_x = 8'h10; in_y = 8'h20; in_last = 1'b1; in_cin = 1'b0; in_sub = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_x = 8'h01; in_y = 8'h02;
      check("t5_a", 32'(obs()), 32'(ex(1, 8'h30, 8'd0, 1, 0, 0, 0)));
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("t5_hold_rdy", 32'(in_ready), 32'd0);
         check("t5_hold_out", 32'(obs()), 32'(ex(1, 8'h30, 8'd0, 1, 0, 0, 0)));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_x = 8'h04; in_y = 8'h04;
      check("t5_b", 32'(obs()), 32'(ex(1, 8'h03, 8'd0, 1, 0, 0, 0)));
      @(posedge clk); #1;
      check("t5_b_held", 32'(obs()), 32'(ex(1, 8'h03, 8'd0, 1, 0, 0, 0)));
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("t5_c", 32'(obs()), 32'(ex(1, 8'h08, 8'd0, 1, 0, 0, 0)));
      @(posedge clk); #1;
      check("t5_c_drain", 32'(out_valid), 32'd0);

      // full-rate four-word add, then back-to-back single-word op with no bubble
      in_valid = 1'b1;
      in_sub = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_x    = (k == 3) ? 8'h12 : 8'hFF;
         in_y    = (k == 3) ? 8'h34 : 8'h00;
         in_cin  = (k == 0);
         in_last = (k == 3);
         @(posedge clk); #1;
         if (k < 3)
            check("t5_rate", 32'(obs()), 32'(ex(1, 8'h00, 8'(k), 0, 0, 0, 1)));
         else
            check("t5_rate_last", 32'(obs()), 32'(ex(1, 8'h47, 8'd3, 1, 0, 0, 0)));
      end
      in_x = 8'h21; in_y = 8'h01; in_cin = 1'b0; in_last = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("t5_nobubble", 32'(obs()), 32'(ex(1, 8'h22, 8'd0, 1, 0, 0, 0)));
      @(posedge clk); #1;

      // 258-beat add: index wraps at 256, carry chain unaffected
      in_valid = 1'b1;
      for (int k = 0; k < 258; k++) begin
         in_x    = (k == 257) ? 8'h00 : 8'hFF;
         in_y    = 8'h00;
         in_cin  = (k == 0);
         in_last = (k == 257);
         @(posedge clk); #1;
         if (k == 255 || k == 256)
            check("t_wrap", 32'(obs()), 32'(ex(1, 8'h00, 8'(k), 0, 0, 0, 1)));
         else if (k == 257)
            check("t_wrap_last", 32'(obs()), 32'(ex(1, 8'h01, 8'd1, 1, 0, 0, 0)));
      end
      in_valid = 1'b0;
      @(posedge clk); #1;

      // reset in the middle of a two-word op
      send(8'hFF, 8'h01, 0, 0, 0);
      check("t6_beat0", 32'(obs()), 32'(ex(1, 8'h00, 8'd0, 0, 0, 0, 1)));
      rst_n = 1'b0;
      #2;
      check("t6_in_reset", 32'(obs()), 32'(ex(0, 8'h00, 8'd0, 0, 0, 0, 0)));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      send(8'h01, 8'h01, 1, 1, 0);
      check("t6_after", 32'(obs()), 32'(ex(1, 8'h03, 8'd0, 1, 0, 0, 0)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
